// File: rtl/xbar_cfg_pkg.sv
// Shared constants, counter widths and FSM encoding for the crossbar config loader.
// Word stream is LSB-first; NUM_WORDS words carry CFG_W select bits plus padding.
package xbar_cfg_pkg;

  localparam int NUM_IN    = 24;
  localparam int NUM_OUT   = 30;
  localparam int SEL_W     = 5;
  localparam int WORD_W    = 16;
  localparam int CFG_W     = NUM_OUT * SEL_W;
  localparam int NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W;

  localparam int WCNT_W = $clog2(NUM_WORDS);
  localparam int FCNT_W = $clog2(NUM_OUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_COMMIT
  } state_t;

  function automatic logic sel_illegal(input logic [SEL_W-1:0] sel);
    return int'(sel) >= NUM_IN;
  endfunction

endpackage

// File: rtl/xbar_cfg_loader_if.sv
// Config-port side of the loader: word stream handshake, control, status and the
// committed select bus that feeds the crossbar.
interface xbar_cfg_loader_if;
  import xbar_cfg_pkg::*;

  logic              io_cfg_start;
  logic              io_cfg_abort;
  logic [WORD_W-1:0] io_cfg_word;
  logic              io_cfg_word_valid;
  logic              io_cfg_word_ready;
  logic              io_busy;
  logic              io_cfg_done;
  logic              io_cfg_error;
  logic [CFG_W-1:0]  io_mux_configs;

  modport master (
    output io_cfg_start,
    output io_cfg_abort,
    output io_cfg_word,
    output io_cfg_word_valid,
    input  io_cfg_word_ready,
    input  io_busy,
    input  io_cfg_done,
    input  io_cfg_error,
    input  io_mux_configs
  );

  modport slave (
    input  io_cfg_start,
    input  io_cfg_abort,
    input  io_cfg_word,
    input  io_cfg_word_valid,
    output io_cfg_word_ready,
    output io_busy,
    output io_cfg_done,
    output io_cfg_error,
    output io_mux_configs
  );

endinterface

// File: rtl/xbar_cfg_field_check.sv
// Selects shadow field f and flags it when it addresses a nonexistent crossbar input.
// Purely combinational; the loader walks f across all fields one per cycle.
module xbar_cfg_field_check
  import xbar_cfg_pkg::*;
(
  input  logic [CFG_W-1:0]  shadow,
  input  logic [FCNT_W-1:0] f,
  output logic              illegal
);

  logic [SEL_W-1:0] field [NUM_OUT];
  logic [SEL_W-1:0] sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_field
      assign field[gi] = shadow[gi*SEL_W +: SEL_W];
    end
  endgenerate

  // Counter codes past the last field read as input 0 so they can never flag.
  always_comb begin
    sel = '0;
    if (int'(f) < NUM_OUT) sel = field[f];
    illegal = sel_illegal(sel);
  end

endmodule

// File: rtl/xbar_cfg_loader.sv
// Collects a full select image into a shadow register, range-checks every field,
// then commits it to the crossbar in one cycle only if all fields are legal.
module xbar_cfg_loader
  import xbar_cfg_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  xbar_cfg_loader_if.slave   cfg
);

  state_t              state_reg, state_next;
  logic [WCNT_W-1:0]   word_cnt_reg, word_cnt_next;
  logic [FCNT_W-1:0]   f_reg, f_next;
  logic                err_flag_reg, err_flag_next;
  logic [CFG_W-1:0]    shadow_reg, shadow_next;
  logic [CFG_W-1:0]    mux_configs_reg, mux_configs_next;
  logic                done_reg, done_next;
  logic                error_reg, error_next;
  logic                word_accept;
  logic                field_illegal;

  // Abort masks ready so a word offered alongside abort is never taken.
  assign word_accept = (state_reg == ST_LOAD) && cfg.io_cfg_word_valid && !cfg.io_cfg_abort;

  xbar_cfg_field_check u_field_check (
    .shadow  (shadow_reg),
    .f       (f_reg),
    .illegal (field_illegal)
  );

  // Padding bits of the final word have no shadow storage and fall away here.
  always_comb begin
    shadow_next = shadow_reg;
    for (int i = 0; i < CFG_W; i++) begin
      if (word_accept && int'(word_cnt_reg) == i / WORD_W)
        shadow_next[i] = cfg.io_cfg_word[i % WORD_W];
    end
  end

  always_comb begin
    state_next       = state_reg;
    word_cnt_next    = word_cnt_reg;
    f_next           = f_reg;
    err_flag_next    = err_flag_reg;
    mux_configs_next = mux_configs_reg;
    done_next        = 1'b0;
    error_next       = error_reg;

    case (state_reg)
      ST_IDLE: begin
        word_cnt_next = '0;
        f_next        = '0;
        err_flag_next = 1'b0;
        if (cfg.io_cfg_start) begin
          error_next = 1'b0;
          state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (cfg.io_cfg_abort) begin
          state_next = ST_IDLE;
        end else if (word_accept) begin
          word_cnt_next = word_cnt_reg + 1'b1;
          if (word_cnt_reg == WCNT_W'(NUM_WORDS - 1)) state_next = ST_CHECK;
        end
      end

      // Fixed-length scan: every field is visited even after the first bad one.
      ST_CHECK: begin
        if (cfg.io_cfg_abort) begin
          state_next = ST_IDLE;
        end else begin
          err_flag_next = err_flag_reg | field_illegal;
          f_next        = f_reg + 1'b1;
          if (f_reg == FCNT_W'(NUM_OUT - 1)) state_next = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        state_next = ST_IDLE;
        if (!err_flag_reg) begin
          mux_configs_next = shadow_reg;
          done_next        = 1'b1;
        end else begin
          error_next = 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      word_cnt_reg    <= '0;
      f_reg           <= '0;
      err_flag_reg    <= 1'b0;
      shadow_reg      <= '0;
      mux_configs_reg <= '0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      word_cnt_reg    <= word_cnt_next;
      f_reg           <= f_next;
      err_flag_reg    <= err_flag_next;
      shadow_reg      <= shadow_next;
      mux_configs_reg <= mux_configs_next;
      done_reg        <= done_next;
      error_reg       <= error_next;
    end
  end

  assign cfg.io_cfg_word_ready = (state_reg == ST_LOAD) && !cfg.io_cfg_abort;
  assign cfg.io_busy           = (state_reg != ST_IDLE);
  assign cfg.io_cfg_done       = done_reg;
  assign cfg.io_cfg_error      = error_reg;
  assign cfg.io_mux_configs    = mux_configs_reg;

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Scoreboard bench: loads push their expected outcome (done/error, image, cycle);
// a negedge monitor pops and compares whenever done pulses or error rises.
module tb_xbar_cfg_loader;
  import xbar_cfg_pkg::*;

  typedef logic [CFG_W-1:0] val_t;
  typedef struct {
    bit   is_err;
    val_t cfg;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  xbar_cfg_loader_if bus();
  xbar_cfg_loader dut (.clk(clk), .reset(reset), .cfg(bus));

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb[$];
  val_t committed;

  task automatic check(input string name, input bit ok, input val_t act, input val_t req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference rule: a load is rejected if any select names an input >= NUM_IN.
  function automatic bit img_illegal(input val_t img);
    for (int i = 0; i < NUM_OUT; i++)
      if (int'(img[i*SEL_W +: SEL_W]) >= NUM_IN) return 1'b1;
    return 1'b0;
  endfunction

  function automatic val_t rand_img(input bit bad);
    val_t r;
    int   idx;
    r = '0;
    for (int i = 0; i < NUM_OUT; i++) r[i*SEL_W +: SEL_W] = SEL_W'($urandom_range(0, NUM_IN - 1));
    if (bad) begin
      idx = int'($urandom_range(0, NUM_OUT - 1));
      r[idx*SEL_W +: SEL_W] = SEL_W'($urandom_range(NUM_IN, 31));
    end
    return r;
  endfunction

  // Monitor: one scoreboard entry per done pulse or error rising edge.
  bit   prev_err = 1'b0;
  bit   prev_done = 1'b0;
  val_t prev_mux = '0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_err  = 1'b0;
      prev_done = 1'b0;
      prev_mux  = '0;
    end else begin
      if (prev_done) check("done_single_pulse", bus.io_cfg_done === 1'b0, val_t'(bus.io_cfg_done), '0);
      if (bus.io_mux_configs !== prev_mux)
        check("mux_changes_only_on_done", bus.io_cfg_done === 1'b1, bus.io_mux_configs, prev_mux);
      if (bus.io_cfg_done === 1'b1 || (bus.io_cfg_error === 1'b1 && !prev_err)) begin
        if (sb.size() == 0) begin
          check("unexpected_completion", 1'b0, val_t'({bus.io_cfg_done, bus.io_cfg_error}), '0);
        end else begin
          e = sb.pop_front();
          check("completion_error", bus.io_cfg_error === e.is_err, val_t'(bus.io_cfg_error), val_t'(e.is_err));
          check("completion_done", bus.io_cfg_done === !e.is_err, val_t'(bus.io_cfg_done), val_t'(!e.is_err));
          check("completion_cycle", cyc == e.due, val_t'(cyc), val_t'(e.due));
          check("mux_configs", bus.io_mux_configs === e.cfg, bus.io_mux_configs, e.cfg);
          check("busy_after_commit", bus.io_busy === 1'b0, val_t'(bus.io_busy), '0);
        end
      end
      prev_err  = (bus.io_cfg_error === 1'b1);
      prev_done = (bus.io_cfg_done === 1'b1);
      prev_mux  = bus.io_mux_configs;
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("completion_timeout", 1'b0, val_t'(sb.size()), '0);
      sb.delete();
    end
  endtask

  // mode 0: valid held high, 1: valid toggles 1/0, 2: random valid.
  task automatic run_load(input val_t img, input int mode, input bit start_glitch);
    logic [NUM_WORDS*WORD_W-1:0] stream;
    int   k = 0, n = 0, cur = 0, last = 0;
    bit   v;
    exp_t e;
    stream = {(NUM_WORDS*WORD_W - CFG_W)'($urandom()), img};
    bus.io_cfg_start = 1'b1;
    @(posedge clk); #1;
    bus.io_cfg_start = 1'b0;
    while (k < NUM_WORDS) begin
      cur = cyc;
      case (mode)
        0:       v = 1'b1;
        1:       v = (n % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.io_cfg_word_valid = v;
      bus.io_cfg_word       = v ? stream[k*WORD_W +: WORD_W] : WORD_W'($urandom());
      bus.io_cfg_start      = start_glitch && (k == 5);
      @(negedge clk);
      if (n == 0) begin
        check("load_busy", bus.io_busy === 1'b1, val_t'(bus.io_busy), val_t'(1));
        check("start_clears_error", bus.io_cfg_error === 1'b0, val_t'(bus.io_cfg_error), '0);
      end
      if (v) check("ready_in_load", bus.io_cfg_word_ready === 1'b1, val_t'(bus.io_cfg_word_ready), val_t'(1));
      @(posedge clk); #1;
      if (v) begin
        last = cur;
        k++;
      end
      n++;
    end
    bus.io_cfg_word_valid = 1'b0;
    bus.io_cfg_start      = 1'b0;
    e.is_err = img_illegal(img);
    e.cfg    = e.is_err ? committed : img;
    e.due    = last + 32;
    if (!e.is_err) committed = img;
    sb.push_back(e);
    wait_drain(200);
  endtask

  // Abort after n_words accepted; with a full image, abort lands `extra` cycles into CHECK.
  task automatic abort_load(input int n_words, input int extra);
    bus.io_cfg_start = 1'b1;
    @(posedge clk); #1;
    bus.io_cfg_start = 1'b0;
    for (int i = 0; i < n_words; i++) begin
      bus.io_cfg_word_valid = 1'b1;
      bus.io_cfg_word       = WORD_W'($urandom());
      @(posedge clk); #1;
    end
    bus.io_cfg_word_valid = (n_words < NUM_WORDS);
    repeat (extra) begin
      @(posedge clk); #1;
    end
    bus.io_cfg_abort = 1'b1;
    @(negedge clk);
    check("ready_low_on_abort", bus.io_cfg_word_ready === 1'b0, val_t'(bus.io_cfg_word_ready), '0);
    @(posedge clk); #1;
    bus.io_cfg_abort      = 1'b0;
    bus.io_cfg_word_valid = 1'b0;
    @(negedge clk);
    check("idle_after_abort", bus.io_busy === 1'b0, val_t'(bus.io_busy), '0);
    repeat (45) @(posedge clk);
    #1;
    check("no_error_after_abort", bus.io_cfg_error === 1'b0, val_t'(bus.io_cfg_error), '0);
    check("mux_kept_after_abort", bus.io_mux_configs === committed, bus.io_mux_configs, committed);
  endtask

  val_t img_mod, img_bad;

  initial begin
    reset                 = 1'b1;
    bus.io_cfg_start      = 1'b0;
    bus.io_cfg_abort      = 1'b0;
    bus.io_cfg_word_valid = 1'b0;
    bus.io_cfg_word       = '0;
    committed             = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mux", bus.io_mux_configs === '0, bus.io_mux_configs, '0);
    check("rst_busy", bus.io_busy === 1'b0, val_t'(bus.io_busy), '0);
    check("rst_ready", bus.io_cfg_word_ready === 1'b0, val_t'(bus.io_cfg_word_ready), '0);
    check("rst_done", bus.io_cfg_done === 1'b0, val_t'(bus.io_cfg_done), '0);
    check("rst_error", bus.io_cfg_error === 1'b0, val_t'(bus.io_cfg_error), '0);
    @(posedge clk); #1;

    for (int i = 0; i < NUM_OUT; i++) img_mod[i*SEL_W +: SEL_W] = SEL_W'(i % NUM_IN);
    run_load(img_mod, 0, 1'b0);
    check("field25", bus.io_mux_configs[25*SEL_W +: SEL_W] === 5'd1, val_t'(bus.io_mux_configs[25*SEL_W +: SEL_W]), val_t'(1));
    check("field29", bus.io_mux_configs[29*SEL_W +: SEL_W] === 5'd5, val_t'(bus.io_mux_configs[29*SEL_W +: SEL_W]), val_t'(5));

    img_bad = img_mod;
    img_bad[17*SEL_W +: SEL_W] = 5'd24;
    run_load(img_bad, 0, 1'b0);
    img_bad[17*SEL_W +: SEL_W] = 5'd31;
    run_load(img_bad, 0, 1'b0);
    run_load(rand_img(1'b0), 0, 1'b0);
    run_load(img_mod, 1, 1'b0);

    abort_load(4, 0);
    abort_load(NUM_WORDS, 5);
    run_load(rand_img(1'b0), 0, 1'b0);

    // Reset lands 20 cycles after start, in the middle of CHECK.
    bus.io_cfg_start = 1'b1;
    @(posedge clk); #1;
    bus.io_cfg_start = 1'b0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      bus.io_cfg_word_valid = 1'b1;
      bus.io_cfg_word       = WORD_W'($urandom());
      @(posedge clk); #1;
    end
    bus.io_cfg_word_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    committed = '0;
    @(negedge clk);
    check("midload_rst_mux", bus.io_mux_configs === '0, bus.io_mux_configs, '0);
    check("midload_rst_busy", bus.io_busy === 1'b0, val_t'(bus.io_busy), '0);
    check("midload_rst_ready", bus.io_cfg_word_ready === 1'b0, val_t'(bus.io_cfg_word_ready), '0);
    check("midload_rst_done", bus.io_cfg_done === 1'b0, val_t'(bus.io_cfg_done), '0);
    check("midload_rst_error", bus.io_cfg_error === 1'b0, val_t'(bus.io_cfg_error), '0);
    @(posedge clk); #1;

    run_load(rand_img(1'b0), 2, 1'b1);
    for (int t = 0; t < 8; t++) run_load(rand_img(1'($urandom_range(0, 1))), 2, 1'($urandom_range(0, 1)));

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
